// File: rtl/huffman_pkg.sv
// Shared constants and FSM state encoding for the Huffman tree-build block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package huffman_pkg;

  localparam int NUM_SYM_DEF = 10;
  localparam int IDX_W_DEF   = 5;
  localparam logic [4:0] NODE_NONE = 5'h1F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    MERGE = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/huffman_merge_ctrl_if.sv
// Selector handshake, status and tree-query signals of the merge controller.
// Latency: n/a (wires only).
// Backpressure: none; strobes are fire-and-forget, the selector must keep up.
interface huffman_merge_ctrl_if
  import huffman_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF
);

  logic             start;
  logic [IDX_W-1:0] min1;
  logic [IDX_W-1:0] min2;
  logic             load_en;
  logic             merge_en;
  logic [IDX_W-1:0] new_root_index;
  logic             busy;
  logic             done;
  logic             err;
  logic [IDX_W-1:0] q_node;
  logic [IDX_W-1:0] q_parent;
  logic             q_bit;

  // Controller side: drives strobes, status and query results.
  modport master (
    input  start, min1, min2, q_node,
    output load_en, merge_en, new_root_index, busy, done, err, q_parent, q_bit
  );

  // Environment side: selector, sequencer and code-generation reader.
  modport slave (
    output start, min1, min2, q_node,
    input  load_en, merge_en, new_root_index, busy, done, err, q_parent, q_bit
  );

endinterface

// File: rtl/huffman_tree_table.sv
// Parent/branch-bit register file for all leaf and branch nodes of the tree.
// Latency: writes land at the clock edge; the read port is combinational.
// Backpressure: none; two writes per cycle always accepted, clear wins over writes.
module huffman_tree_table
  import huffman_pkg::*;
#(
  parameter int NUM_SYM = NUM_SYM_DEF,
  parameter int IDX_W   = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wa_en,
  input  logic [IDX_W-1:0] wa_addr,
  input  logic             wb_en,
  input  logic [IDX_W-1:0] wb_addr,
  input  logic [IDX_W-1:0] wr_parent,
  input  logic [IDX_W-1:0] q_node,
  output logic [IDX_W-1:0] q_parent,
  output logic             q_bit
);

  localparam int               NENT     = 2 * NUM_SYM - 1;
  localparam logic [IDX_W-1:0] NENT_IDX = IDX_W'(NENT);
  localparam logic [IDX_W-1:0] NONE     = '1;

  logic [IDX_W-1:0] parent_q [NENT];
  logic [IDX_W-1:0] parent_d [NENT];
  logic             bit_q    [NENT];
  logic             bit_d    [NENT];

  // Next table contents: clear everything, or apply the min1 (bit 0) and min2 (bit 1) writes.
  always_comb begin
    for (int i = 0; i < NENT; i++) begin
      parent_d[i] = parent_q[i];
      bit_d[i]    = bit_q[i];
    end
    if (clr) begin
      for (int i = 0; i < NENT; i++) begin
        parent_d[i] = NONE;
        bit_d[i]    = 1'b0;
      end
    end else begin
      if (wa_en && (wa_addr < NENT_IDX)) begin
        parent_d[wa_addr] = wr_parent;
        bit_d[wa_addr]    = 1'b0;
      end
      if (wb_en && (wb_addr < NENT_IDX)) begin
        parent_d[wb_addr] = wr_parent;
        bit_d[wb_addr]    = 1'b1;
      end
    end
  end

  // Table storage with synchronous reset to "no parent".
  always_ff @(posedge clk) begin
    for (int i = 0; i < NENT; i++) begin
      if (!rst_n) begin
        parent_q[i] <= NONE;
        bit_q[i]    <= 1'b0;
      end else begin
        parent_q[i] <= parent_d[i];
        bit_q[i]    <= bit_d[i];
      end
    end
  end

  // Query port; addresses past the last branch node read as an empty entry.
  always_comb begin
    q_parent = NONE;
    q_bit    = 1'b0;
    if (q_node < NENT_IDX) begin
      q_parent = parent_q[q_node];
      q_bit    = bit_q[q_node];
    end
  end

endmodule

// File: rtl/huffman_merge_ctrl.sv
// Sequences LOAD then NUM_SYM-1 back-to-back merges, allocating branch indices and recording parents.
// Latency: start to done is NUM_SYM+1 cycles, fixed even when a merge is flagged bad.
// Backpressure: none; start ignored while busy, honoured in IDLE and in the DONE cycle.
module huffman_merge_ctrl
  import huffman_pkg::*;
#(
  parameter int NUM_SYM = NUM_SYM_DEF,
  parameter int IDX_W   = IDX_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  huffman_merge_ctrl_if.master bus
);

  localparam logic [IDX_W-1:0] NONE      = '1;
  localparam logic [IDX_W-1:0] ROOT_BASE = IDX_W'(NUM_SYM);
  localparam logic [IDX_W-1:0] LAST_CNT  = IDX_W'(NUM_SYM - 2);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] merge_cnt_q, merge_cnt_d;
  logic [IDX_W-1:0] new_root_q, new_root_d;
  logic             load_en_q, load_en_d;
  logic             merge_en_q, merge_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             tbl_clr;
  logic             bad_pair;
  logic             tbl_wr;

  // A merge is bad if the selector offers the same node twice or runs out of nodes.
  assign bad_pair = (bus.min1 == bus.min2) || (bus.min1 == NONE) || (bus.min2 == NONE);
  assign tbl_wr   = (state_q == MERGE) && !bad_pair;

  // Next state, counters and output decodes; outputs are decoded from the next state so they come straight off flops.
  always_comb begin
    state_d     = state_q;
    merge_cnt_d = merge_cnt_q;
    err_d       = err_q;
    tbl_clr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d     = LOAD;
          merge_cnt_d = '0;
          err_d       = 1'b0;
          tbl_clr     = 1'b1;
        end
      end
      LOAD: begin
        state_d     = MERGE;
        merge_cnt_d = '0;
      end
      MERGE: begin
        if (bad_pair) begin
          err_d = 1'b1;
        end
        merge_cnt_d = merge_cnt_q + 1'b1;
        if (merge_cnt_q == LAST_CNT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          state_d     = LOAD;
          merge_cnt_d = '0;
          err_d       = 1'b0;
          tbl_clr     = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    load_en_d  = (state_d == LOAD);
    merge_en_d = (state_d == MERGE);
    busy_d     = (state_d == LOAD) || (state_d == MERGE);
    done_d     = (state_d == DONE);
    new_root_d = (state_d == MERGE) ? (ROOT_BASE + merge_cnt_d) : '0;
  end

  // FSM and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      merge_cnt_q <= '0;
      new_root_q  <= '0;
      load_en_q   <= 1'b0;
      merge_en_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      merge_cnt_q <= merge_cnt_d;
      new_root_q  <= new_root_d;
      load_en_q   <= load_en_d;
      merge_en_q  <= merge_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.load_en        = load_en_q;
  assign bus.merge_en       = merge_en_q;
  assign bus.new_root_index = new_root_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.err            = err_q;

  huffman_tree_table #(
    .NUM_SYM (NUM_SYM),
    .IDX_W   (IDX_W)
  ) u_table (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (tbl_clr),
    .wa_en     (tbl_wr),
    .wa_addr   (bus.min1),
    .wb_en     (tbl_wr),
    .wb_addr   (bus.min2),
    .wr_parent (new_root_q),
    .q_node    (bus.q_node),
    .q_parent  (bus.q_parent),
    .q_bit     (bus.q_bit)
  );

endmodule

// File: tb/tb_huffman_merge_ctrl.sv
// Directed bench: real two-minimum selector model plus a stub selector for error cases.
// Latency: checks the fixed start->done timeline cycle by cycle.
// Backpressure: n/a.
module tb_huffman_merge_ctrl;
  import huffman_pkg::*;

  localparam logic [4:0] NONE = NODE_NONE;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   kind  = 0;   // 0 real selector, 1 dup at merge 4, 2 min2 NONE at merge 1, 3 clean stub

  huffman_merge_ctrl_if #(.IDX_W(5)) bus ();

  huffman_merge_ctrl #(.NUM_SYM(10), .IDX_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural two-minimum selector: ties resolved towards the lower node index.
  int         w   [0:18];
  logic       act [0:18];
  logic [4:0] r1, r2, mcnt, sm1, sm2;
  int         b1, b2;

  // Selector state: latch counts on load_en, combine the two minima on merge_en.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 19; i++) begin
        act[i] <= 1'b0;
        w[i]   <= 0;
      end
    end else if (bus.load_en) begin
      for (int i = 0; i < 19; i++) begin
        act[i] <= (i < 10);
        w[i]   <= (i < 10) ? i + 1 : 0;
      end
    end else if (bus.merge_en && bus.min1 < 5'd19 && bus.min2 < 5'd19 && bus.min1 != bus.min2) begin
      w[bus.new_root_index]   <= w[bus.min1] + w[bus.min2];
      act[bus.new_root_index] <= 1'b1;
      act[bus.min1]           <= 1'b0;
      act[bus.min2]           <= 1'b0;
    end
  end

  // Combinational minimum search over active nodes.
  always_comb begin
    r1 = NONE; r2 = NONE; b1 = 0; b2 = 0;
    for (int i = 0; i < 19; i++) begin
      if (act[i] === 1'b1) begin
        if (r1 == NONE || w[i] < b1) begin
          r2 = r1; b2 = b1; r1 = 5'(i); b1 = w[i];
        end else if (r2 == NONE || w[i] < b2) begin
          r2 = 5'(i); b2 = w[i];
        end
      end
    end
  end

  // Merge counter used by the stub selector.
  always @(posedge clk) begin
    if (!rst_n || bus.load_en) mcnt <= 5'd0;
    else if (bus.merge_en)     mcnt <= mcnt + 5'd1;
  end

  // Stub pairs: min1 = m, min2 = 18 - m, with faults injected per kind.
  always_comb begin
    sm1 = mcnt;
    sm2 = 5'd18 - mcnt;
    if (kind == 1 && mcnt == 5'd3) sm2 = 5'd3;
    if (kind == 2 && mcnt == 5'd0) sm2 = NONE;
  end

  assign bus.min1 = (kind == 0) ? r1 : sm1;
  assign bus.min2 = (kind == 0) ? r2 : sm2;

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  // Pulse start so that it is sampled at edge 0; returns at the cycle-1 sample point.
  task automatic kick();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
  endtask

  task automatic query(input logic [4:0] n);
    bus.q_node = n;
    #1;
  endtask

  task automatic test_reset();
    n_cmp++; if (bus.load_en !== 1'b0) begin n_bad++; $display("FAIL rst_load_en got %b want 0", bus.load_en); end
    n_cmp++; if (bus.merge_en !== 1'b0) begin n_bad++; $display("FAIL rst_merge_en got %b want 0", bus.merge_en); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b want 0", bus.done); end
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL rst_err got %b want 0", bus.err); end
    n_cmp++; if (bus.new_root_index !== 5'd0) begin n_bad++; $display("FAIL rst_nri got %0d want 0", bus.new_root_index); end
    query(5'd0);
    n_cmp++; if (bus.q_parent !== NONE) begin n_bad++; $display("FAIL rst_q0 got %0d want 31", bus.q_parent); end
  endtask

  task automatic test_basic();
    logic [4:0] exp_nri;
    kind = 0;
    kick();
    n_cmp++; if (bus.load_en !== 1'b1 || bus.busy !== 1'b1) begin n_bad++; $display("FAIL c1_load got load_en=%b busy=%b want 1/1", bus.load_en, bus.busy); end
    n_cmp++; if (bus.merge_en !== 1'b0) begin n_bad++; $display("FAIL c1_merge_en got %b want 0", bus.merge_en); end
    for (int c = 2; c <= 10; c++) begin
      step();
      exp_nri = 5'(8 + c);
      n_cmp++; if (bus.merge_en !== 1'b1 || bus.load_en !== 1'b0 || bus.done !== 1'b0) begin n_bad++; $display("FAIL merge_c%0d got merge_en=%b load_en=%b done=%b want 1/0/0", c, bus.merge_en, bus.load_en, bus.done); end
      n_cmp++; if (bus.new_root_index !== exp_nri) begin n_bad++; $display("FAIL nri_c%0d got %0d want %0d", c, bus.new_root_index, exp_nri); end
    end
    step();
    n_cmp++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.merge_en !== 1'b0) begin n_bad++; $display("FAIL c11_done got done=%b busy=%b merge_en=%b want 1/0/0", bus.done, bus.busy, bus.merge_en); end
    n_cmp++; if (bus.new_root_index !== 5'd0) begin n_bad++; $display("FAIL c11_nri got %0d want 0", bus.new_root_index); end
    step();
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL c12_done got %b want 0", bus.done); end
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL basic_err got %b want 0", bus.err); end
    query(5'd0);
    n_cmp++; if (bus.q_parent !== 5'd10 || bus.q_bit !== 1'b0) begin n_bad++; $display("FAIL q0 got %0d/%b want 10/0", bus.q_parent, bus.q_bit); end
    query(5'd1);
    n_cmp++; if (bus.q_parent !== 5'd10 || bus.q_bit !== 1'b1) begin n_bad++; $display("FAIL q1 got %0d/%b want 10/1", bus.q_parent, bus.q_bit); end
    query(5'd2);
    n_cmp++; if (bus.q_parent !== 5'd11 || bus.q_bit !== 1'b0) begin n_bad++; $display("FAIL q2 got %0d/%b want 11/0", bus.q_parent, bus.q_bit); end
    @(negedge clk);
    query(5'd10);
    n_cmp++; if (bus.q_parent !== 5'd11 || bus.q_bit !== 1'b1) begin n_bad++; $display("FAIL q10 got %0d/%b want 11/1", bus.q_parent, bus.q_bit); end
    query(5'd18);
    n_cmp++; if (bus.q_parent !== NONE || bus.q_bit !== 1'b0) begin n_bad++; $display("FAIL q18 got %0d/%b want 31/0", bus.q_parent, bus.q_bit); end
    query(5'd19);
    n_cmp++; if (bus.q_parent !== NONE || bus.q_bit !== 1'b0) begin n_bad++; $display("FAIL q19 got %0d/%b want 31/0", bus.q_parent, bus.q_bit); end
    query(5'd31);
    n_cmp++; if (bus.q_parent !== NONE || bus.q_bit !== 1'b0) begin n_bad++; $display("FAIL q31 got %0d/%b want 31/0", bus.q_parent, bus.q_bit); end
  endtask

  task automatic test_reset_mid();
    int dirty, dones;
    kind = 0;
    kick();
    while (cyc < 5) step();
    rst_n = 1'b0;
    step();
    n_cmp++; if (bus.busy !== 1'b0 || bus.merge_en !== 1'b0 || bus.new_root_index !== 5'd0) begin n_bad++; $display("FAIL midrst_out got busy=%b merge_en=%b nri=%0d want 0/0/0", bus.busy, bus.merge_en, bus.new_root_index); end
    rst_n = 1'b1;
    dirty = 0;
    for (int n = 0; n < 19; n++) begin
      bus.q_node = 5'(n);
      #0.1;
      if (bus.q_parent !== NONE) dirty++;
    end
    n_cmp++; if (dirty !== 0) begin n_bad++; $display("FAIL midrst_table got %0d non-NONE entries want 0", dirty); end
    dones = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (bus.done !== 1'b0) dones++;
    end
    n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL midrst_done got %0d done pulses want 0", dones); end
  endtask

  task automatic test_start_ignored_and_done();
    int seen;
    kind = 0;
    kick();
    while (cyc < 5) step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    n_cmp++; if (bus.merge_en !== 1'b1 || bus.new_root_index !== 5'd14) begin n_bad++; $display("FAIL ign_c6 got merge_en=%b nri=%0d want 1/14", bus.merge_en, bus.new_root_index); end
    while (cyc < 10) step();
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL ign_c10_done got %b want 0", bus.done); end
    step();
    n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL ign_c11_done got %b want 1", bus.done); end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    n_cmp++; if (bus.load_en !== 1'b1 || bus.busy !== 1'b1) begin n_bad++; $display("FAIL restart_load got load_en=%b busy=%b want 1/1", bus.load_en, bus.busy); end
    query(5'd0);
    n_cmp++; if (bus.q_parent !== NONE) begin n_bad++; $display("FAIL restart_clear got %0d want 31", bus.q_parent); end
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      step();
      if (bus.done === 1'b1) seen = i + 2;
    end
    n_cmp++; if (seen !== 11) begin n_bad++; $display("FAIL restart_done got cycle %0d want 11", seen); end
  endtask

  task automatic test_dup_err();
    kind = 1;
    kick();
    while (cyc < 5) step();
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL dup_c5_err got %b want 0", bus.err); end
    step();
    n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL dup_c6_err got %b want 1", bus.err); end
    while (cyc < 11) step();
    n_cmp++; if (bus.done !== 1'b1 || bus.err !== 1'b1) begin n_bad++; $display("FAIL dup_c11 got done=%b err=%b want 1/1", bus.done, bus.err); end
    step();
    n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL dup_sticky got %b want 1", bus.err); end
    query(5'd3);
    n_cmp++; if (bus.q_parent !== NONE) begin n_bad++; $display("FAIL dup_q3 got %0d want 31", bus.q_parent); end
    query(5'd15);
    n_cmp++; if (bus.q_parent !== NONE) begin n_bad++; $display("FAIL dup_q15 got %0d want 31", bus.q_parent); end
    query(5'd2);
    n_cmp++; if (bus.q_parent !== 5'd12 || bus.q_bit !== 1'b0) begin n_bad++; $display("FAIL dup_q2 got %0d/%b want 12/0", bus.q_parent, bus.q_bit); end
    query(5'd16);
    n_cmp++; if (bus.q_parent !== 5'd12 || bus.q_bit !== 1'b1) begin n_bad++; $display("FAIL dup_q16 got %0d/%b want 12/1", bus.q_parent, bus.q_bit); end
  endtask

  task automatic test_none_err();
    kind = 2;
    kick();
    step();
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL none_c2_err got %b want 0", bus.err); end
    step();
    n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL none_c3_err got %b want 1", bus.err); end
    while (cyc < 12) step();
    kind = 3;
    kick();
    n_cmp++; if (bus.err !== 1'b0 || bus.load_en !== 1'b1) begin n_bad++; $display("FAIL none_clear got err=%b load_en=%b want 0/1", bus.err, bus.load_en); end
    while (cyc < 11) step();
    n_cmp++; if (bus.done !== 1'b1 || bus.err !== 1'b0) begin n_bad++; $display("FAIL clean_c11 got done=%b err=%b want 1/0", bus.done, bus.err); end
    step();
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.q_node = 5'd0;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_basic();
    test_reset_mid();
    test_start_ignored_and_done();
    test_dup_err();
    test_none_err();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout got no completion want summary");
    $fatal(1);
  end

endmodule
